preif_nextpc_gen: RTL and testbench
===================================

Name: preif_nextpc_gen

Overview:
- Parametrised next-PC generator and pre-fetch stage for the LoongArch pipeline front end.
- Owns the fetch PC register, computes next PC with redirect priority (exception > ertn > branch > sequential), and drives the synchronous inst RAM address with next PC.
- Presents an aligned fetch block of FETCH_WIDTH slots to IF through a valid/allowin handshake.
- Generalises the single-issue, stateless pre-IF: internal PC state, boot sequencing, branch valid/ack handshake, multi-slot fetch mask, ADEF detection.

Parameters:
- PC_WIDTH, 32, PC/address width.
- RESET_PC, 32'h1C00_0000, first fetch address after reset.
- FETCH_WIDTH, 1, instructions per fetch block; power of two, 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_allowin_i  in  1  IF can accept a fetch block this cycle
- preif_to_if_valid_o  out  1  fetch block valid toward IF
- excep_en_i  in  1  exception redirect pulse from CSR/WB
- excep_entry_pc_i  in  PC_WIDTH  exception entry
- ertn_en_i  in  1  ertn redirect pulse
- ertn_pc_i  in  PC_WIDTH  ERA target
- br_valid_i  in  1  ID branch redirect request, held until acked
- br_pc_i  in  PC_WIDTH  branch target
- br_ack_o  out  1  branch request consumed this cycle
- pc_o  out  PC_WIDTH  PC of current fetch block (first valid slot)
- slot_mask_o  out  FETCH_WIDTH  valid slots in current block
- adef_o  out  1  pc_o misaligned (pc_o[1:0] != 0)
- inst_sram_en_o  out  1  inst RAM read enable
- inst_sram_addr_o  out  PC_WIDTH  inst RAM address (= nextpc)

Behaviour:
- Reset (async): state=BOOT, pc_r=RESET_PC-4*FETCH_WIDTH (unused), valid=0, br_ack_o=0. Outputs: preif_to_if_valid_o=0, slot_mask_o=0, adef_o=0.
- FSM BOOT: nextpc=RESET_PC, inst_sram_en_o=1. Next edge: pc_r<=RESET_PC, state<=RUN. Redirect inputs ignored; br_ack_o=0.
- FSM RUN: preif_to_if_valid_o=1. fire = valid & if_allowin_i.
- BLK = 4*FETCH_WIDTH.
- seq = (pc_r & ~(BLK-1)) + BLK. Width truncates mod 2^PC_WIDTH; wrap allowed.
- nextpc priority, combinational:
  - excep_en_i -> excep_entry_pc_i
  - else ertn_en_i -> ertn_pc_i
  - else br_valid_i -> br_pc_i
  - else fire -> seq
  - else pc_r (hold, so the RAM re-reads the same address and data persists across an IF stall)
- pc_r<=nextpc every RUN edge. inst_sram_en_o=1 in RUN. inst_sram_addr_o=nextpc.
- Redirects load regardless of if_allowin_i. Unaccepted current block is discarded. A block fired in the same cycle as a redirect is wrong-path; the source stage flushes it. No redirect is lost while IF stalls.
- br_ack_o = RUN & br_valid_i & ~excep_en_i & ~ertn_en_i. Single cycle per request. A branch masked by excep/ertn is not acked; ID drops it on flush.
- slot_mask_o bit k = 1 iff k >= pc_r[log2(BLK)-1:2]. FETCH_WIDTH=1 gives mask=1.
- adef_o = valid & (pc_r[1:0] != 0). The block is still presented; slot_mask_o is unchanged. The misaligned PC is not corrected.
- excep_en_i and ertn_en_i together: exception wins.
- Reset asserted mid-operation returns to BOOT immediately; valid drops asynchronously.

Decomposition:
- Shared package: PC_WIDTH, RESET_PC default, redirect bus widths, state encoding BOOT/RUN.
- One natural sub-module, preif_slot_mask: pc offset -> slot_mask_o, parametrised by FETCH_WIDTH.

Test Plan:
- Reset release, FW=1, allowin=1 -> inst_sram_addr_o=1C000000 during BOOT; pc_o=1C000000, 1C000004, 1C000008 on successive cycles; valid=1 from first RUN cycle.
- allowin=0 for 3 cycles at pc=1C000008 -> pc_o and inst_sram_addr_o hold 1C000008; resume -> 1C00000C.
- br_valid_i=1, br_pc=1C000100, allowin=0 -> br_ack_o=1 same cycle; next pc_o=1C000100; held br_valid next cycle acks again (ID responsibility).
- excep_en_i, ertn_en_i and br_valid_i together, entry=1C008000 -> pc_o=1C008000 next cycle; br_ack_o=0.
- FW=4, ertn_pc=1C000018 -> pc_o=1C000018, slot_mask_o=4'b1100; next pc_o=1C000020, mask=4'b1111.
- Branch to 1C000102 -> adef_o=1 with pc_o=1C000102; reset asserted mid-stream -> valid=0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/preif_nextpc_gen_pkg.sv
// preif_nextpc_gen_pkg: shared widths, reset PC, FSM encoding and slot-offset width helper for the pre-IF stage
package preif_nextpc_gen_pkg;
  localparam int PC_WIDTH_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h1C00_0000;
  localparam int BR_BUS_WIDTH = PC_WIDTH_DEF + 1;
  localparam int REDIR_BUS_WIDTH = 2 * PC_WIDTH_DEF + 2;
  typedef enum logic {BOOT, RUN} state_t;
  function automatic int off_w(input int fw);
    return fw > 1 ? $clog2(fw) : 1;
  endfunction
endpackage

// File: rtl/preif_nextpc_gen_slot_mask.sv
// preif_slot_mask: word offset inside a fetch block -> mask of slots at or after that offset (ports: off in, mask out)
module preif_slot_mask
  import preif_nextpc_gen_pkg::*;
#(
  parameter int FETCH_WIDTH = 1,
  localparam int OW = off_w(FETCH_WIDTH)
) (
  input  logic [OW-1:0]          off,
  output logic [FETCH_WIDTH-1:0] mask
);
  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
    assign mask[k] = (FETCH_WIDTH == 1) || (int'(off) <= k);
  end
endmodule

// File: rtl/preif_nextpc_gen.sv
// preif_nextpc_gen: fetch PC register, prioritised next-PC select (excep > ertn > branch > sequential > hold), inst RAM address drive; ports: clk/rst, IF valid/allowin handshake, excep/ertn/branch redirects with branch ack, pc_o/slot_mask_o/adef_o block info, inst_sram_en_o/inst_sram_addr_o
module preif_nextpc_gen
  import preif_nextpc_gen_pkg::*;
#(
  parameter int                  PC_WIDTH    = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RESET_PC_DEF),
  parameter int                  FETCH_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_allowin_i,
  output logic                   preif_to_if_valid_o,
  input  logic                   excep_en_i,
  input  logic [PC_WIDTH-1:0]    excep_entry_pc_i,
  input  logic                   ertn_en_i,
  input  logic [PC_WIDTH-1:0]    ertn_pc_i,
  input  logic                   br_valid_i,
  input  logic [PC_WIDTH-1:0]    br_pc_i,
  output logic                   br_ack_o,
  output logic [PC_WIDTH-1:0]    pc_o,
  output logic [FETCH_WIDTH-1:0] slot_mask_o,
  output logic                   adef_o,
  output logic                   inst_sram_en_o,
  output logic [PC_WIDTH-1:0]    inst_sram_addr_o
);
  localparam int BLK = 4 * FETCH_WIDTH;
  localparam int OW = off_w(FETCH_WIDTH);
  state_t state, state_nx;
  logic [PC_WIDTH-1:0] pc_r, nextpc, seq;
  logic [FETCH_WIDTH-1:0] mask;
  logic run, fire;
  assign run = state == RUN;
  assign fire = run & if_allowin_i;
  assign seq = (pc_r & ~PC_WIDTH'(BLK - 1)) + PC_WIDTH'(BLK);
  // BOOT ignores redirects; holding pc_r on a stall makes the RAM re-read so its data persists
  always_comb begin
    state_nx = RUN;
    nextpc = !run        ? RESET_PC :
             excep_en_i  ? excep_entry_pc_i :
             ertn_en_i   ? ertn_pc_i :
             br_valid_i  ? br_pc_i :
             fire        ? seq : pc_r;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      pc_r <= RESET_PC - PC_WIDTH'(BLK);
    end else begin
      state <= state_nx;
      pc_r <= nextpc;
    end
  end
  preif_slot_mask #(.FETCH_WIDTH(FETCH_WIDTH)) u_slot_mask (
    .off  (pc_r[OW+1:2]),
    .mask (mask)
  );
  assign preif_to_if_valid_o = run;
  assign br_ack_o = run & br_valid_i & ~excep_en_i & ~ertn_en_i;
  assign pc_o = pc_r;
  assign slot_mask_o = run ? mask : '0;
  assign adef_o = run & (pc_r[1:0] != 2'b00);
  assign inst_sram_en_o = 1'b1;
  assign inst_sram_addr_o = nextpc;
endmodule

// File: tb/tb_preif_nextpc_gen.sv
// tb_preif_nextpc_gen: directed vectors with queued expectations, checked by a negedge monitor on FW=1 and FW=4 instances
module tb_preif_nextpc_gen;
  typedef struct {
    bit          sel;
    logic        valid;
    logic [31:0] pc;
    logic        ack;
    logic [31:0] addr;
    logic        adef;
    logic [3:0]  mask;
  } exp_t;

  logic clk = 0, rst = 1;
  logic allow = 0, exc = 0, ertn = 0, br = 0;
  logic [31:0] br_pc = 0;
  logic [31:0] exc_pc = 32'h1C00_8000;
  logic [31:0] ertn_pc = 32'h1C00_0018;
  logic v1, a1, d1, en1, v4, a4, d4, en4;
  logic [31:0] p1, ad1, p4, ad4;
  logic [0:0] m1;
  logic [3:0] m4;
  exp_t q[$];
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  preif_nextpc_gen dut1 (
    .clk(clk), .rst(rst), .if_allowin_i(allow), .preif_to_if_valid_o(v1),
    .excep_en_i(exc), .excep_entry_pc_i(exc_pc), .ertn_en_i(ertn), .ertn_pc_i(ertn_pc),
    .br_valid_i(br), .br_pc_i(br_pc), .br_ack_o(a1), .pc_o(p1), .slot_mask_o(m1),
    .adef_o(d1), .inst_sram_en_o(en1), .inst_sram_addr_o(ad1)
  );

  preif_nextpc_gen #(.FETCH_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .if_allowin_i(allow), .preif_to_if_valid_o(v4),
    .excep_en_i(exc), .excep_entry_pc_i(exc_pc), .ertn_en_i(ertn), .ertn_pc_i(ertn_pc),
    .br_valid_i(br), .br_pc_i(br_pc), .br_ack_o(a4), .pc_o(p4), .slot_mask_o(m4),
    .adef_o(d4), .inst_sram_en_o(en4), .inst_sram_addr_o(ad4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("valid", e.sel ? 32'(v4)  : 32'(v1),  32'(e.valid));
      chk("pc",    e.sel ? p4       : p1,       e.pc);
      chk("ack",   e.sel ? 32'(a4)  : 32'(a1),  32'(e.ack));
      chk("addr",  e.sel ? ad4      : ad1,      e.addr);
      chk("adef",  e.sel ? 32'(d4)  : 32'(d1),  32'(e.adef));
      chk("mask",  e.sel ? 32'(m4)  : 32'(m1),  32'(e.mask));
      chk("sram_en", e.sel ? 32'(en4) : 32'(en1), 32'd1);
    end
  end

  task automatic step(input bit s, input bit r, input bit al, input bit ex, input bit er,
                      input bit b, input logic [31:0] bpc, input logic ev, input logic [31:0] ep,
                      input logic ea, input logic [31:0] ead, input logic edf, input logic [3:0] em);
    exp_t e;
    rst = r; allow = al; exc = ex; ertn = er; br = b; br_pc = bpc;
    e.sel = s; e.valid = ev; e.pc = ep; e.ack = ea; e.addr = ead; e.adef = edf; e.mask = em;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    //   sel rst al ex er br  br_pc         valid pc            ack addr          adef mask
    step(0, 1, 1, 0, 0, 0, 32'h0,        0, 32'h1BFF_FFFC, 0, 32'h1C00_0000, 0, 4'h0);
    step(0, 0, 1, 0, 0, 0, 32'h0,        0, 32'h1BFF_FFFC, 0, 32'h1C00_0000, 0, 4'h0);
    step(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h1C00_0000, 0, 32'h1C00_0004, 0, 4'h1);
    step(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h1C00_0004, 0, 32'h1C00_0008, 0, 4'h1);
    step(0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h1C00_0008, 0, 32'h1C00_0008, 0, 4'h1);
    step(0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h1C00_0008, 0, 32'h1C00_0008, 0, 4'h1);
    step(0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h1C00_0008, 0, 32'h1C00_0008, 0, 4'h1);
    step(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h1C00_0008, 0, 32'h1C00_000C, 0, 4'h1);
    step(0, 0, 0, 0, 0, 1, 32'h1C00_0100, 1, 32'h1C00_000C, 1, 32'h1C00_0100, 0, 4'h1);
    step(0, 0, 0, 0, 0, 1, 32'h1C00_0100, 1, 32'h1C00_0100, 1, 32'h1C00_0100, 0, 4'h1);
    step(0, 0, 1, 1, 1, 1, 32'h1C00_0100, 1, 32'h1C00_0100, 0, 32'h1C00_8000, 0, 4'h1);
    step(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h1C00_8000, 0, 32'h1C00_8004, 0, 4'h1);
    step(0, 0, 1, 0, 0, 1, 32'h1C00_0102, 1, 32'h1C00_8004, 1, 32'h1C00_0102, 0, 4'h1);
    step(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h1C00_0102, 0, 32'h1C00_0104, 1, 4'h1);
    step(0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h1C00_0104, 0, 32'h1C00_0104, 0, 4'h1);
    step(0, 1, 1, 0, 0, 1, 32'h1C00_0200, 0, 32'h1BFF_FFFC, 0, 32'h1C00_0000, 0, 4'h0);
    step(0, 0, 1, 1, 0, 1, 32'h1C00_0200, 0, 32'h1BFF_FFFC, 0, 32'h1C00_0000, 0, 4'h0);
    step(0, 0, 1, 0, 0, 0, 32'h0,        1, 32'h1C00_0000, 0, 32'h1C00_0004, 0, 4'h1);
    step(1, 1, 1, 0, 0, 0, 32'h0,        0, 32'h1BFF_FFF0, 0, 32'h1C00_0000, 0, 4'h0);
    step(1, 0, 1, 0, 0, 0, 32'h0,        0, 32'h1BFF_FFF0, 0, 32'h1C00_0000, 0, 4'h0);
    step(1, 0, 1, 0, 0, 0, 32'h0,        1, 32'h1C00_0000, 0, 32'h1C00_0010, 0, 4'hF);
    step(1, 0, 1, 0, 1, 0, 32'h0,        1, 32'h1C00_0010, 0, 32'h1C00_0018, 0, 4'hF);
    step(1, 0, 1, 0, 0, 0, 32'h0,        1, 32'h1C00_0018, 0, 32'h1C00_0020, 0, 4'hC);
    step(1, 0, 0, 0, 0, 1, 32'h1C00_001E, 1, 32'h1C00_0020, 1, 32'h1C00_001E, 0, 4'hF);
    step(1, 0, 1, 0, 0, 0, 32'h0,        1, 32'h1C00_001E, 0, 32'h1C00_0020, 1, 4'h8);
    step(1, 0, 1, 0, 0, 0, 32'h0,        1, 32'h1C00_0020, 0, 32'h1C00_0030, 0, 4'hF);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
